// File: rtl/output_buffer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obuf_sched_pkg
// Description : Shared types and constants for the output buffer scheduler.
//               Provides the controller state encoding and the width of the
//               optional stall statistics counter.
// Revision    : 1.0 - initial release
// ============================================================================
package obuf_sched_pkg;

  // Controller states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Width of the saturating stall counter (only used when stall stats exist).
  localparam int STALL_CNT_W = 16;

endpackage : obuf_sched_pkg
`default_nettype wire

// File: rtl/output_buffer_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter with a combinational grant.
//               When both lanes request, the lane that did not win last time
//               is granted. The last-winner register only moves on a grant.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset
//               valid   - per-lane request [1:0]
//               enable  - grants are allowed this cycle
//               grant   - one-hot grant [1:0], zero when nothing granted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  // 1 = lane 1 won the last grant. Resets to 1 so lane 0 wins the first tie.
  logic r_last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (|grant) begin
      r_last_grant <= grant[1];
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/output_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : output_buffer_scheduler
// Description : Output buffer RAM controller. Arbitrates two result lanes
//               into a circular buffer, drains stored words to a valid/ready
//               consumer and runs an end-of-frame flush sequence.
// Ports       : clk, rst                 - clock / synchronous active-high reset
//               req{0,1}_valid/data/ready - producer lanes (ready = grant)
//               buf_wr_cs/en/addr/data    - buffer write port
//               buf_rd_cs/en/addr/data    - buffer read port (1-cycle latency)
//               out_valid/out_data/out_ready - consumer handshake
//               flush_req / flush_done    - flush request level / done pulse
//               count, full, empty        - occupancy status
//               stall_cnt                 - saturating stall counter, present
//                                           only with OBUF_SCHED_STALL_STATS_EN
// Options     : OBUF_SCHED_STALL_STATS_EN - adds stall_cnt output and logic
// Revision    : 1.0 - initial release
// ============================================================================
module output_buffer_scheduler
  import obuf_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int RAM_DEPTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [DATA_WIDTH-1:0]  req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  output logic                   req1_ready,
  output logic                   buf_wr_cs,
  output logic                   buf_wr_en,
  output logic [ADDR_WIDTH-1:0]  buf_wr_addr,
  output logic [DATA_WIDTH-1:0]  buf_wr_data,
  output logic                   buf_rd_cs,
  output logic                   buf_rd_en,
  output logic [ADDR_WIDTH-1:0]  buf_rd_addr,
  input  logic [DATA_WIDTH-1:0]  buf_rd_data,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic [ADDR_WIDTH:0]    count,
  output logic                   full,
`ifdef OBUF_SCHED_STALL_STATS_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  output logic                   empty
);

  localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_out_valid;
  logic                  r_flush_done;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  state_e                w_state_nxt;
  logic [1:0]            w_grant;
  logic                  w_any_grant;
  logic                  w_rd_issue;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_arb_en;
  logic                  w_flush_fin;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_inc;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_inc;

  // Both full and empty look only at the registered count: a read freeing a
  // slot cannot enable a grant in the same cycle, and a fresh write cannot be
  // read back in the cycle it is written.
  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .enable (w_arb_en),
    .grant  (w_grant)
  );

  assign w_any_grant = |w_grant;

  // A new read may be issued whenever the output register is free or is
  // being emptied this cycle, which sustains one word per cycle.
  assign w_rd_issue = !w_empty && (!r_out_valid || out_ready);

  assign w_wr_ptr_inc = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
  assign w_rd_ptr_inc = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;

  always_comb begin
    w_count_nxt = r_count;
    if (w_any_grant && !w_rd_issue) begin
      w_count_nxt = r_count + c_CNT_ONE;
    end else if (!w_any_grant && w_rd_issue) begin
      w_count_nxt = r_count - c_CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and read pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_any_grant) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_rd_issue) begin
        r_rd_ptr    <= w_rd_ptr_inc;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Controller FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= w_flush_fin;
    end
  end

  // --------------------------------------------------------------------------
  // Controller FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (flush_req) begin
          w_state_nxt = FLUSH;
        end else if (w_any_grant) begin
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (flush_req) begin
          w_state_nxt = FLUSH;
        end else if (w_count_nxt == '0) begin
          w_state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (w_flush_fin) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Controller FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // A flush request also blocks grants in the cycle it is first seen, so
    // nothing new slips in behind the words being drained.
    w_arb_en    = (r_state != FLUSH) && !flush_req && !w_full;
    // Done once nothing is stored, no read is in flight and the consumer
    // has taken the last word.
    w_flush_fin = (r_state == FLUSH) && w_empty && !r_out_valid;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req0_ready  = w_grant[0];
  assign req1_ready  = w_grant[1];
  assign buf_wr_cs   = w_any_grant;
  assign buf_wr_en   = w_any_grant;
  assign buf_wr_addr = r_wr_ptr;
  assign buf_wr_data = w_grant[1] ? req1_data : req0_data;
  assign buf_rd_cs   = w_rd_issue;
  assign buf_rd_en   = w_rd_issue;
  assign buf_rd_addr = r_rd_ptr;
  assign out_valid   = r_out_valid;
  assign out_data    = buf_rd_data;
  assign flush_done  = r_flush_done;
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;

`ifdef OBUF_SCHED_STALL_STATS_EN
  // --------------------------------------------------------------------------
  // Stall statistics: cycles where a lane waits because of full or flush
  // --------------------------------------------------------------------------
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_stall;

  assign w_stall = (req0_valid || req1_valid) && !w_any_grant &&
                   (w_full || (r_state == FLUSH) || flush_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule : output_buffer_scheduler
`default_nettype wire

// File: tb/tb_output_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_buffer_scheduler
// Description : Directed self-checking bench for output_buffer_scheduler.
//               A behavioural buffer RAM sits on the write/read ports; words
//               accepted from the lanes are queued as expected output and
//               compared in order as the consumer handshakes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_buffer_scheduler;
  import obuf_sched_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          buf_wr_cs, buf_wr_en, buf_rd_cs, buf_rd_en;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  logic [DW-1:0] buf_wr_data, buf_rd_data, out_data;
  logic          out_valid, flush_done, full, empty;
  logic          out_ready = 1'b0, flush_req = 1'b0;
  logic [AW:0]   count;
`ifdef OBUF_SCHED_STALL_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt;
`endif

  output_buffer_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .buf_wr_cs(buf_wr_cs), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data),
    .buf_rd_cs(buf_rd_cs), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush_req(flush_req), .flush_done(flush_done),
    .count(count), .full(full),
`ifdef OBUF_SCHED_STALL_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Behavioural buffer RAM: data appears one cycle after the read strobe.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (buf_wr_cs && buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
    if (buf_rd_cs && buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
  end

  int            total = 0;
  int            bad   = 0;
  int            fd_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer-side scoreboard and invariant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_word", 64'(out_data), 64'hDEAD);
        else                   check("sb_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
      check("count_le_depth", 64'(count <= DEPTH), 64'd1);
      if (flush_done) fd_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data  = '0;   req1_data  = '0;
    flush_req  = 1'b0; out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    tick();
    tick();
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    idle_inputs();
    tick();
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_wr_cs", 64'(buf_wr_cs), 64'd0);
    check("rst_rd_cs", 64'(buf_rd_cs), 64'd0);
    rst = 1'b0;

    // ---------------- lane 0 only, 5 words, draining ----------------
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1;
      req0_data  = 32'hA0 + i;
      #1;
      check("t1_ready0", 64'(req0_ready), 64'd1);
      check("t1_wr_addr", 64'(buf_wr_addr), 64'(i));
      exp_q.push_back(req0_data);
      // First grant in cycle 0: read issues in cycle 1, data valid in cycle 2.
      if (i == 1) check("t1_ovalid_c1", 64'(out_valid), 64'd0);
      if (i == 2) check("t1_ovalid_c2", 64'(out_valid), 64'd1);
      if (i == 2) check("t1_first_data", 64'(out_data), 64'hA0);
      tick();
    end
    drain("t1_drain", 20);
    check("t1_count0", 64'(count), 64'd0);

    // ---------------- both lanes, alternating grants ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1; req0_data = 32'h1000 + i;
      req1_valid = 1'b1; req1_data = 32'h2000 + i;
      #1;
      check("t2_ready0", 64'(req0_ready), 64'((i % 2) == 0));
      check("t2_ready1", 64'(req1_ready), 64'((i % 2) == 1));
      check("t2_wr_data", 64'(buf_wr_data), ((i % 2) == 0) ? 64'(req0_data) : 64'(req1_data));
      exp_q.push_back(((i % 2) == 0) ? req0_data : req1_data);
      tick();
    end
    drain("t2_drain", 30);

    // ---------------- fill to full, single release ----------------
    do_reset();
    // With the consumer stalled, one word sits in the output stage, so 65
    // grants leave 64 entries in the buffer.
    for (int i = 0; i <= DEPTH; i++) begin
      req0_valid = 1'b1; req0_data = 32'h3000 + i;
      #1;
      check("t3_fill_ready", 64'(req0_ready), 64'd1);
      exp_q.push_back(req0_data);
      tick();
    end
    req0_data = 32'h3FFE; req1_valid = 1'b1; req1_data = 32'h3FFF;
    #1;
    check("t3_full", 64'(full), 64'd1);
    check("t3_count64", 64'(count), 64'd64);
    check("t3_full_ready0", 64'(req0_ready), 64'd0);
    check("t3_full_ready1", 64'(req1_ready), 64'd0);
    check("t3_no_read", 64'(buf_rd_cs), 64'd0);
    tick();
    out_ready = 1'b1;
    #1;
    check("t3_rel_read", 64'(buf_rd_cs), 64'd1);
    check("t3_rel_nogrant", 64'({req1_ready, req0_ready}), 64'd0);
    tick();
    out_ready = 1'b0;
    #1;
    check("t3_count63", 64'(count), 64'd63);
    // Lane 0 won every previous grant, so lane 1 wins the tie now.
    check("t3_regrant1", 64'(req1_ready), 64'd1);
    check("t3_regrant0", 64'(req0_ready), 64'd0);
    exp_q.push_back(req1_data);
    tick();
    check("t3_refull", 64'(full), 64'd1);
    check("t3_refull_ready", 64'({req1_ready, req0_ready}), 64'd0);
    drain("t3_drain", 200);

    // ---------------- 70 words with continuous drain: wrap ----------------
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      req0_valid = 1'b1; req0_data = 32'h4000 + i;
      #1;
      check("t4_ready", 64'(req0_ready), 64'd1);
      check("t4_wr_addr", 64'(buf_wr_addr), 64'(i % DEPTH));
      exp_q.push_back(req0_data);
      tick();
    end
    drain("t4_drain", 20);

    // ---------------- flush with 3 stored words ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_data = 32'h5000 + i;
      #1;
      exp_q.push_back(req0_data);
      tick();
    end
    req0_valid = 1'b0;
    begin
      int fd0;
      bit seen;
      fd0  = fd_cnt;
      seen = 1'b0;
      flush_req = 1'b1; req1_valid = 1'b1; req1_data = 32'h5FFF;
      #1;
      check("t5_req_nogrant", 64'(req1_ready), 64'd0);
      tick();
      flush_req = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 20 && !seen; n++) begin
        #1;
        if (flush_done) begin
          seen = 1'b1;
          req1_valid = 1'b0;
        end else begin
          check("t5_flush_nogrant", 64'(req1_ready), 64'd0);
          tick();
        end
      end
      check("t5_done_seen", 64'(seen), 64'd1);
      check("t5_count0", 64'(count), 64'd0);
      check("t5_drained", 64'(exp_q.size()), 64'd0);
      tick(); tick(); tick();
      check("t5_done_once", 64'(fd_cnt - fd0), 64'd1);
      // Back in IDLE: a new word must be accepted.
      req0_valid = 1'b1; req0_data = 32'h5ABC;
      #1;
      check("t5_idle_grant", 64'(req0_ready), 64'd1);
      exp_q.push_back(req0_data);
      tick();
      drain("t5_drain", 20);
    end

    // ---------------- flush while empty ----------------
    do_reset();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1;
    check("t5b_done_c1", 64'(flush_done), 64'd0);
    tick();
    check("t5b_done_c2", 64'(flush_done), 64'd1);
    tick();
    check("t5b_done_c3", 64'(flush_done), 64'd0);

    // ---------------- reset mid-drain ----------------
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req0_valid = 1'b1; req0_data = 32'h6000 + i;
      tick();
    end
    req0_valid = 1'b0;
    #1;
    check("t6_count10", 64'(count), 64'd10);
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_count0", 64'(count), 64'd0);
    check("t6_ovalid0", 64'(out_valid), 64'd0);
    check("t6_empty", 64'(empty), 64'd1);
`ifdef OBUF_SCHED_STALL_STATS_EN
    check("t6_stall0", 64'(stall_cnt), 64'd0);
`endif
    tick();
    check("t6_stay_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_output_buffer_scheduler
`default_nettype wire
